md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL provide ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: start  input  1  EX-stage request to begin an operation; sampled only in IDLE.
REQ-004 SHALL provide: op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL provide: operand_a  input  32  multiplicand or dividend (rs).
REQ-006 SHALL provide: operand_b  input  32  multiplier or divisor (rt).
REQ-007 SHALL provide: flush  input  1  synchronous abort of an in-flight operation.
REQ-008 SHALL provide: mthi_we, mtlo_we  input  1 each  direct HI or LO write enables.
REQ-009 SHALL provide: wdata  input  32  data for MTHI/MTLO.
REQ-010 SHALL provide: busy  output  1  high while state != IDLE; drives pipeline stall.
REQ-011 SHALL provide: done  output  1  one-cycle pulse after HI/LO updated by an operation.
REQ-012 SHALL provide: hi, lo  output  32 each  architectural HI/LO registers (MFHI/MFLO source).

Function
REQ-013 FSM states SHALL be IDLE, RUN, FINISH.
REQ-014 IDLE with start=1 at edge E0 SHALL latch op and operands, clear iteration counter (5 bits), go RUN.
REQ-015 Edges E1..E32 in RUN SHALL each perform one iteration; edge where counter = 31 SHALL go FINISH.
REQ-016 Edge E33 in FINISH SHALL apply sign correction, write hi/lo, go IDLE; done SHALL be 1 in the cycle after E33 only.
REQ-017 busy SHALL be 1 in cycles 1..33 after start; fixed latency 33 cycles, independent of operand values.
REQ-018 start while busy=1 SHALL be ignored (no queuing).
REQ-019 MULTU SHALL produce 64-bit unsigned product {hi,lo} via shift-add.
REQ-020 MULT SHALL operate on magnitudes, negating the 64-bit result if operand signs differ; 0x80000000 magnitude is handled as unsigned 2^31.
REQ-021 DIVU SHALL use restoring shift-subtract: lo = quotient, hi = remainder.
REQ-022 DIV SHALL truncate quotient toward zero; remainder sign SHALL equal dividend sign; 0x80000000 / -1 SHALL give lo=0x80000000, hi=0.
REQ-023 Divisor 0 (DIVU or DIV) SHALL give hi=operand_a, lo=0xFFFFFFFF, normal latency, done pulsed.
REQ-024 mthi_we/mtlo_we in IDLE SHALL write wdata to hi/lo at that edge; while busy=1 they SHALL be ignored.
REQ-025 start and mthi_we/mtlo_we in the same IDLE cycle: write SHALL apply; operation result later overwrites hi/lo.
REQ-026 flush=1 in RUN or FINISH SHALL return to IDLE at next edge with hi/lo unchanged and no done; flush in IDLE SHALL have no effect; flush beats start.

Reset
REQ-027 reset=1 SHALL asynchronously force state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, operand latches 0.
REQ-028 reset during RUN/FINISH SHALL discard the operation; no done after release.
REQ-029 First start SHALL be accepted on the first rising edge with reset=0.

Structure
REQ-030 Shared package md_pkg SHALL hold op encodings, FSM state type, and constant MD_ITERS=32.
REQ-031 Iteration datapath (64-bit accumulator, shift, add/subtract, restore) SHALL be sub-module md_iter_core; md_sequencer holds FSM, counter, HI/LO, sign handling.
REQ-032 hi/lo and done SHALL be driven directly from flops.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after start edge, busy 33 cycles.
REQ-034 MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU 100 / 0 -> hi=100, lo=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 MTHI 0x1234 then DIVU 10/3 with start pulsed again at cycle 5 -> second start ignored, hi=1, lo=3, single done.
REQ-037 flush at cycle 10 of MULTU with hi=0xAA preloaded -> IDLE next cycle, hi=0xAA, no done; async reset at cycle 20 -> all outputs 0 immediately.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, FSM state type and iteration count for the multiply/divide unit
package md_pkg;
    localparam int MD_ITERS = 32;
    typedef logic [1:0] md_op_t;
    localparam md_op_t OP_MULTU = 2'b00;
    localparam md_op_t OP_MULT  = 2'b01;
    localparam md_op_t OP_DIVU  = 2'b10;
    localparam md_op_t OP_DIV   = 2'b11;
    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE   = 2'd0;
    localparam md_state_t ST_RUN    = 2'd1;
    localparam md_state_t ST_FINISH = 2'd2;
    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: 64-bit accumulator doing one shift-add or restoring shift-subtract step per cycle
module md_iter_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] acc
);
    logic [63:0] acc_q, acc_d, mul_next, div_next;
    logic [31:0] b_q, b_d;
    logic [32:0] sum, rem_top;
    logic        ge;
    always_comb begin
        sum      = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? b_q : 32'd0};
        mul_next = {sum, acc_q[31:1]};
        rem_top  = acc_q[63:31];
        ge       = rem_top >= {1'b0, b_q};
        div_next = {ge ? rem_top[31:0] - b_q : rem_top[31:0], acc_q[30:0], ge};
        acc_d    = load ? {32'd0, a} : step ? (is_div ? div_next : mul_next) : acc_q;
        b_d      = load ? b : b_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end
    assign acc = acc_q;
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: fixed 33-cycle multiply/divide sequencer owning FSM, counter, HI/LO and sign handling
module md_sequencer
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [4:0] LAST = 5'(MD_ITERS - 1);
    md_state_t   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    md_op_t      op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d, accept, neg;
    logic [63:0] acc, prod, res;
    logic [31:0] quo, rem;
    assign accept = (state_q == ST_IDLE) && start && !flush;
    md_iter_core u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (state_q == ST_RUN),
        .is_div (op_q[1]),
        .a      (md_mag(operand_a, op[0])),
        .b      (md_mag(operand_b, op[0])),
        .acc    (acc)
    );
    always_comb begin
        neg  = op_q[0] && (a_q[31] ^ b_q[31]);
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[31:0] : acc[31:0];
        rem  = (op_q[0] && a_q[31]) ? -acc[63:32] : acc[63:32];
        res  = !op_q[1] ? prod : (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem, quo};
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            hi_d = mthi_we ? wdata : hi_q;
            lo_d = mtlo_we ? wdata : lo_q;
            if (accept) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                op_d    = op;
                a_d     = operand_a;
                b_d     = operand_b;
            end
        end else if (flush) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN) begin
            cnt_d   = cnt_q + 5'd1;
            state_d = (cnt_q == LAST) ? ST_FINISH : ST_RUN;
        end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            hi_d    = res[63:32];
            lo_d    = res[31:0];
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULTU;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign busy = state_q != ST_IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: table-driven, random and hand-written sequences checked against an arithmetic reference model
module tb_md_sequencer;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic        mthi_we = 1'b0, mtlo_we = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = '0, operand_b = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    md_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .mthi_we   (mthi_we),
        .mtlo_we   (mtlo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'b00) return 64'(a) * 64'(b);
        if (o == 2'b01) return sa * sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string nm);
        int edges, bc;
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        bc = 0;
        while (!done && edges < 40) begin
            if (busy) bc++;
            tick();
            edges++;
        end
        check({nm, " latency"}, 64'(edges), 64'd33);
        check({nm, " busy cycles"}, 64'(bc), 64'd33);
        check({nm, " hi:lo"}, {hi, lo}, exp);
        tick();
        check({nm, " done pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        vec_t tbl[$];
        int dn, de;
        logic [63:0] got;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        tbl.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
        tbl.push_back('{2'b01, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB});
        tbl.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD});
        tbl.push_back('{2'b10, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF});
        tbl.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000});
        tbl.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
        tbl.push_back('{2'b11, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD});
        tbl.push_back('{2'b11, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF});
        tbl.push_back('{2'b10, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF});
        tbl.push_back('{2'b00, 32'd0,         32'h1234_5678, 64'h0});

        tick();
        tick();
        check("reset busy", 64'(busy), 0);
        check("reset done", 64'(done), 0);
        check("reset hi:lo", {hi, lo}, 0);

        reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? 32'($urandom_range(1, 300)) : $urandom);
            if ($urandom_range(0, 1)) ra = 32'($signed(-$signed(32'($urandom_range(0, 1000)))));
            run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d", i));
        end

        // MTHI/MTLO then DIVU with an ignored restart and ignored busy write
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h1234;
        tick();
        mthi_we = 1'b0; mtlo_we = 1'b0;
        check("mthi", 64'(hi), 64'h1234);
        check("mtlo", 64'(lo), 64'h1234);
        op = 2'b10; operand_a = 32'd10; operand_b = 32'd3; start = 1'b1;
        tick();
        dn = 0; de = 0; got = '0;
        for (int k = 1; k <= 45; k++) begin
            start = (k == 5);
            operand_a = (k == 5) ? 32'd50 : 32'd10;
            mthi_we = (k == 7);
            wdata = 32'hFFFF;
            tick();
            if (done) begin
                dn++;
                de = k;
                got = {hi, lo};
            end
        end
        start = 1'b0; mthi_we = 1'b0;
        check("restart done count", 64'(dn), 1);
        check("restart done edge", 64'(de), 33);
        check("restart hi:lo", got, {32'd1, 32'd3});

        // write and start in the same idle cycle
        mthi_we = 1'b1; wdata = 32'h5555;
        op = 2'b00; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
        tick();
        mthi_we = 1'b0; start = 1'b0;
        check("same-cycle write", 64'(hi), 64'h5555);
        repeat (33) tick();
        check("same-cycle done", 64'(done), 1);
        check("same-cycle result", {hi, lo}, 64'd6);

        // flush mid-operation
        mthi_we = 1'b1; wdata = 32'hAA;
        tick();
        mthi_we = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("idle flush busy", 64'(busy), 0);
        check("idle flush hi", 64'(hi), 64'hAA);
        op = 2'b00; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("pre-flush busy", 64'(busy), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(busy), 0);
        check("flush hi:lo", {hi, lo}, {32'hAA, 32'd6});
        dn = 0;
        repeat (40) begin
            tick();
            if (done) dn++;
        end
        check("flush no done", 64'(dn), 0);

        // async reset mid-operation
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2;
        reset = 1'b1;
        #1;
        check("async reset busy", 64'(busy), 0);
        check("async reset hi:lo", {hi, lo}, 0);
        check("async reset done", 64'(done), 0);
        tick();
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            tick();
            if (done) dn++;
        end
        check("reset no done", 64'(dn), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
